// File: rtl/door_access_scheduler.sv
// Arbitrates Wi-Fi / presence-sensor lock requests and sequences the lock FSM in1/in2 lines.
// Define DOOR_LOCKOUT_EN to enable the lockout state after MAX_FAILS consecutive auth failures.
module door_access_scheduler #(
  parameter int RELOCK_CYCLES  = 1000,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int MAX_FAILS      = 3,
  parameter int CW             = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wifi_req,
  input  logic                           wifi_cmd,
  input  logic                           wifi_auth,
  input  logic                           sensor_req,
  input  logic                           sensor_cmd,
  input  logic                           sensor_auth,
  output logic                           wifi_gnt,
  output logic                           sensor_gnt,
  output logic                           lock_in1,
  output logic                           lock_in2,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FAIL_MAX    = FW'(MAX_FAILS);
  localparam logic [CW-1:0] RELOCK_LOAD = CW'(RELOCK_CYCLES);
  localparam int TIMER_NEED = (RELOCK_CYCLES > LOCKOUT_CYCLES) ? RELOCK_CYCLES : LOCKOUT_CYCLES;

  // One timer is shared between relock and lockout, so it must hold the larger count.
  generate
    if ((TIMER_NEED >> CW) != 0) begin : g_cw_check
      $error("door_access_scheduler: CW too narrow for RELOCK_CYCLES/LOCKOUT_CYCLES");
    end
  endgenerate

`ifdef DOOR_LOCKOUT_EN
  localparam logic [CW-1:0] LOCKOUT_LOAD = CW'(LOCKOUT_CYCLES);
  typedef enum logic [2:0] {S_RESYNC, S_IDLE, S_GRANT, S_DRIVE, S_LOCKOUT} state_t;
`else
  typedef enum logic [2:0] {S_RESYNC, S_IDLE, S_GRANT, S_DRIVE} state_t;
`endif

  state_t          r_state;
  logic            r_ptr;
  logic            r_winner;
  logic            r_cmd;
  logic [CW-1:0]   r_timer;
  logic [FW-1:0]   r_fail_cnt;
  logic            r_wifi_gnt;
  logic            r_sensor_gnt;
  logic            r_lock_in1;
  logic            r_lock_in2;
  logic            r_unlocked;
`ifdef DOOR_LOCKOUT_EN
  logic            r_lockout;
`endif

  logic            w_any_req;
  logic            w_winner;
  logic            w_auth;
  logic            w_relock_due;
  logic [FW-1:0]   w_fail_next;

  // Winner encoding: 0 = Wi-Fi, 1 = sensor; the pointer only matters on contention.
  assign w_any_req    = wifi_req | sensor_req;
  assign w_winner     = (wifi_req & sensor_req) ? r_ptr : sensor_req;
  assign w_auth       = r_winner ? sensor_auth : wifi_auth;
  assign w_relock_due = r_unlocked & (r_timer == '0);
  assign w_fail_next  = r_fail_cnt + FW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_RESYNC;
      r_ptr        <= 1'b0;
      r_winner     <= 1'b0;
      r_cmd        <= 1'b0;
      r_timer      <= '0;
      r_fail_cnt   <= '0;
      r_wifi_gnt   <= 1'b0;
      r_sensor_gnt <= 1'b0;
      r_lock_in1   <= 1'b0;
      r_lock_in2   <= 1'b0;
      r_unlocked   <= 1'b0;
`ifdef DOOR_LOCKOUT_EN
      r_lockout    <= 1'b0;
`endif
    end else begin
      if (r_unlocked && (r_timer != '0)) begin
        r_timer <= r_timer - CW'(1);
      end
      r_wifi_gnt   <= 1'b0;
      r_sensor_gnt <= 1'b0;
      r_lock_in1   <= 1'b0;
      r_lock_in2   <= 1'b0;

      case (r_state)
        S_RESYNC: begin
          r_lock_in1 <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_IDLE: begin
          // Relock wins over requests; a pending request is simply sampled again later.
          if (w_relock_due) begin
            r_lock_in1 <= 1'b1;
            r_unlocked <= 1'b0;
            r_state    <= S_DRIVE;
          end else if (w_any_req) begin
            r_winner     <= w_winner;
            r_ptr        <= ~w_winner;
            r_cmd        <= w_winner ? sensor_cmd : wifi_cmd;
            r_wifi_gnt   <= ~w_winner;
            r_sensor_gnt <= w_winner;
            r_state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_auth) begin
            r_fail_cnt <= '0;
            r_lock_in1 <= ~r_cmd;
            r_lock_in2 <= r_cmd;
            r_unlocked <= r_cmd;
            if (r_cmd) begin
              r_timer <= RELOCK_LOAD;
            end
            r_state <= S_DRIVE;
          end else begin
`ifdef DOOR_LOCKOUT_EN
            r_fail_cnt <= w_fail_next;
            if (w_fail_next == FAIL_MAX) begin
              r_lockout <= 1'b1;
              r_timer   <= LOCKOUT_LOAD;
              r_state   <= S_LOCKOUT;
            end else begin
              r_state <= S_IDLE;
            end
`else
            if (r_fail_cnt != FAIL_MAX) begin
              r_fail_cnt <= w_fail_next;
            end
            r_state <= S_IDLE;
`endif
          end
        end
        S_DRIVE: begin
          r_state <= S_IDLE;
        end
`ifdef DOOR_LOCKOUT_EN
        S_LOCKOUT: begin
          if (r_timer == '0) begin
            r_fail_cnt <= '0;
            r_lockout  <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer - CW'(1);
          end
        end
`endif
        default: begin
          r_state <= S_RESYNC;
        end
      endcase
    end
  end

  assign wifi_gnt   = r_wifi_gnt;
  assign sensor_gnt = r_sensor_gnt;
  assign lock_in1   = r_lock_in1;
  assign lock_in2   = r_lock_in2;
  assign unlocked   = r_unlocked;
  assign fail_cnt   = r_fail_cnt;
`ifdef DOOR_LOCKOUT_EN
  assign lockout    = r_lockout;
`else
  assign lockout    = 1'b0;
`endif

endmodule

// File: tb/tb_door_access_scheduler.sv
// Directed bench for door_access_scheduler: grant/drive scoreboard plus cycle-exact checks.
// Expectations follow DOOR_LOCKOUT_EN when it is defined for the build.
module tb_door_access_scheduler;

  localparam int RELOCK_C  = 8;
  localparam int LOCKOUT_C = 20;
  localparam int MAXF      = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wifi_req = 1'b0, wifi_cmd = 1'b0, wifi_auth = 1'b0;
  logic       sensor_req = 1'b0, sensor_cmd = 1'b0, sensor_auth = 1'b0;
  logic       wifi_gnt, sensor_gnt, lock_in1, lock_in2, unlocked, lockout;
  logic [1:0] fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit         gnt_q[$];
  logic [1:0] drv_q[$];
  bit         tb_ptr = 1'b0;

  door_access_scheduler #(
    .RELOCK_CYCLES (RELOCK_C),
    .LOCKOUT_CYCLES(LOCKOUT_C),
    .MAX_FAILS     (MAXF),
    .CW            (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wifi_req   (wifi_req),
    .wifi_cmd   (wifi_cmd),
    .wifi_auth  (wifi_auth),
    .sensor_req (sensor_req),
    .sensor_cmd (sensor_cmd),
    .sensor_auth(sensor_auth),
    .wifi_gnt   (wifi_gnt),
    .sensor_gnt (sensor_gnt),
    .lock_in1   (lock_in1),
    .lock_in2   (lock_in2),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] code(input bit c);
    return c ? 2'b01 : 2'b10;
  endfunction

  // Scoreboard: every grant pulse and every non-idle drive must match the next expectation.
  always @(negedge clk) begin : mon
    bit         w;
    logic [1:0] d;
    if (wifi_gnt || sensor_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_gnt", {30'd0, sensor_gnt, wifi_gnt}, 32'd0);
      end else begin
        w = gnt_q.pop_front();
        chk("gnt_who", {30'd0, sensor_gnt, wifi_gnt}, w ? 32'd2 : 32'd1);
        $display("gnt: wifi=%0b sensor=%0b", wifi_gnt, sensor_gnt);
      end
    end
    if (lock_in1 || lock_in2) begin
      if (drv_q.size() == 0) begin
        chk("unexpected_drive", {30'd0, lock_in1, lock_in2}, 32'd0);
      end else begin
        d = drv_q.pop_front();
        chk("drive_code", {30'd0, lock_in1, lock_in2}, {30'd0, d});
        $display("drive: in1in2=%0b%0b unlocked_next", lock_in1, lock_in2);
      end
    end
  end

  // Raise one request, wait (bounded) for its grant, withdraw, then step one cycle.
  task automatic request(input bit who, input bit cmd, input bit auth);
    int  n;
    bit  got;
    gnt_q.push_back(who);
    if (auth) drv_q.push_back(code(cmd));
    tb_ptr = ~who;
    if (who) begin
      sensor_req = 1'b1; sensor_cmd = cmd; sensor_auth = auth;
    end else begin
      wifi_req = 1'b1; wifi_cmd = cmd; wifi_auth = auth;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = who ? sensor_gnt : wifi_gnt;
    end while (!got && n < 20);
    chk("gnt_wait", {31'd0, got}, 32'd1);
    wifi_req   = 1'b0;
    sensor_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nd, budget, cnt;
    bit rw, rs, p, c_first, c_second;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wifi_gnt", {31'd0, wifi_gnt}, 32'd0);
    chk("rst_sensor_gnt", {31'd0, sensor_gnt}, 32'd0);
    chk("rst_lock_in", {30'd0, lock_in1, lock_in2}, 32'd0);
    chk("rst_unlocked", {31'd0, unlocked}, 32'd0);
    chk("rst_lockout", {31'd0, lockout}, 32'd0);
    chk("rst_fail_cnt", {30'd0, fail_cnt}, 32'd0);

    // Release with a Wi-Fi unlock already pending: RESYNC lock, grant, unlock drive
    drv_q.push_back(2'b10);
    gnt_q.push_back(1'b0);
    drv_q.push_back(2'b01);
    reset_n = 1'b1; wifi_req = 1'b1; wifi_cmd = 1'b1; wifi_auth = 1'b1;
    @(negedge clk);
    chk("resync_drive", {30'd0, lock_in1, lock_in2}, 32'd2);
    @(negedge clk);
    chk("first_gnt", {31'd0, wifi_gnt}, 32'd1);
    wifi_req = 1'b0;
    tb_ptr = 1'b1;
    @(negedge clk);
    chk("unlock_drive", {30'd0, lock_in1, lock_in2}, 32'd1);
    chk("unlocked_set", {31'd0, unlocked}, 32'd1);

    // Auto-relock: timer hits 0 at the start of DRIVE+8, detected there, driven at DRIVE+9
    drv_q.push_back(2'b10);
    repeat (RELOCK_C) @(negedge clk);
    chk("relock_not_yet", {30'd0, lock_in1, lock_in2}, 32'd0);
    chk("relock_still_unlocked", {31'd0, unlocked}, 32'd1);
    @(negedge clk);
    chk("relock_drive", {30'd0, lock_in1, lock_in2}, 32'd2);
    chk("relock_unlocked_clr", {31'd0, unlocked}, 32'd0);
    @(negedge clk);

    // Round-robin with both requests held; winner re-raises with the opposite cmd
    p = tb_ptr;
    c_first  = p ? 1'b1 : 1'b0;
    c_second = p ? 1'b0 : 1'b1;
    gnt_q.push_back(p); gnt_q.push_back(~p); gnt_q.push_back(p);
    drv_q.push_back(code(c_first)); drv_q.push_back(code(c_second)); drv_q.push_back(code(~c_first));
    wifi_cmd = 1'b0; sensor_cmd = 1'b1; wifi_auth = 1'b1; sensor_auth = 1'b1;
    wifi_req = 1'b1; sensor_req = 1'b1;
    nd = 0; rw = 0; rs = 0; budget = 0;
    while (nd < 3 && budget < 60) begin
      @(negedge clk);
      budget++;
      if (rw) begin wifi_req = 1'b1; wifi_cmd = ~wifi_cmd; rw = 0; end
      if (rs) begin sensor_req = 1'b1; sensor_cmd = ~sensor_cmd; rs = 0; end
      if (wifi_gnt)   begin nd++; wifi_req = 1'b0;   rw = (nd < 3); end
      if (sensor_gnt) begin nd++; sensor_req = 1'b0; rs = (nd < 3); end
    end
    wifi_req = 1'b0; sensor_req = 1'b0;
    tb_ptr = ~p;
    chk("rr_grant_count", nd, 32'd3);
    repeat (4) @(negedge clk);
    chk("rr_queues_drained", gnt_q.size() + drv_q.size(), 32'd0);
    chk("rr_end_locked", {31'd0, unlocked}, 32'd0);

    // Consecutive failed authentications from the sensor
    request(1'b1, 1'b0, 1'b0);
    chk("fail_cnt_1", {30'd0, fail_cnt}, 32'd1);
    request(1'b1, 1'b0, 1'b0);
    chk("fail_cnt_2", {30'd0, fail_cnt}, 32'd2);
    request(1'b1, 1'b0, 1'b0);
    chk("fail_cnt_3", {30'd0, fail_cnt}, 32'd3);
`ifdef DOOR_LOCKOUT_EN
    chk("lockout_rise", {31'd0, lockout}, 32'd1);
    // A Wi-Fi request raised during lockout must be ignored (no expectation queued)
    wifi_req = 1'b1; wifi_cmd = 1'b0; wifi_auth = 1'b1;
    cnt = 0;
    while (lockout === 1'b1 && cnt < LOCKOUT_C + 10) begin
      cnt++;
      if (cnt == 5) wifi_req = 1'b0;
      @(negedge clk);
    end
    wifi_req = 1'b0;
    chk("lockout_len", cnt, LOCKOUT_C + 1);
    chk("lockout_fail_clr", {30'd0, fail_cnt}, 32'd0);
`else
    chk("no_lockout", {31'd0, lockout}, 32'd0);
    request(1'b1, 1'b0, 1'b0);
    chk("fail_cnt_sat", {30'd0, fail_cnt}, 32'd3);
    chk("no_lockout_4", {31'd0, lockout}, 32'd0);
`endif
    request(1'b1, 1'b0, 1'b1);
    chk("fail_cnt_clr_on_auth", {30'd0, fail_cnt}, 32'd0);
    repeat (2) @(negedge clk);

    // Unlock, then a failure, then reset asserted during the next GRANT cycle
    request(1'b0, 1'b1, 1'b1);
    chk("pre_abort_unlocked", {31'd0, unlocked}, 32'd1);
    request(1'b1, 1'b0, 1'b0);
    chk("pre_abort_fail", {30'd0, fail_cnt}, 32'd1);
    gnt_q.push_back(1'b0);
    wifi_req = 1'b1; wifi_cmd = 1'b1; wifi_auth = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!wifi_gnt && cnt < 20);
    chk("abort_gnt", {31'd0, wifi_gnt}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    wifi_req = 1'b0;
    chk("abort_gnt_clr", {30'd0, sensor_gnt, wifi_gnt}, 32'd0);
    chk("abort_no_drive", {30'd0, lock_in1, lock_in2}, 32'd0);
    chk("abort_unlocked", {31'd0, unlocked}, 32'd0);
    chk("abort_fail_cnt", {30'd0, fail_cnt}, 32'd0);
    chk("abort_lockout", {31'd0, lockout}, 32'd0);
    @(negedge clk);
    drv_q.push_back(2'b10);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_resync", {30'd0, lock_in1, lock_in2}, 32'd2);
    repeat (6) @(negedge clk);
    chk("gnt_q_empty", gnt_q.size(), 32'd0);
    chk("drv_q_empty", drv_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
